// File: rtl/systolic_feeder_pkg.sv
// Shared types and default sizing for the systolic array operand feeder.
package systolic_feeder_pkg;

  localparam int DEFAULT_DIM = 8;
  localparam int DEFAULT_DW  = 32;
  localparam int KLEN_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN
  } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_skew.sv
// One skew lane: a DEPTH-stage shift register carrying {en, cm, data} toward the array edge.
module skew_line
  import systolic_feeder_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int DW    = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cm,
  input  logic [DW-1:0] data,
  output logic          tap_en,
  output logic          tap_cm,
  output logic [DW-1:0] tap_data
);

  typedef struct packed {
    logic          en;
    logic          cm;
    logic [DW-1:0] data;
  } slot_t;

  slot_t stage [DEPTH];

  // Data and cm are zeroed at the entry point, so a bubble is all-zero at every tap.
  always_ff @(posedge clk) begin
    // NOTE: every stage is reset, so a job aborted mid-flight leaves nothing behind in the line.
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage take its neighbour's pre-edge value.
      stage[0] <= {en, en & cm, en ? data : {DW{1'b0}}};
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign tap_en   = stage[DEPTH-1].en;
  assign tap_cm   = stage[DEPTH-1].cm;
  assign tap_data = stage[DEPTH-1].data;

endmodule

// File: rtl/systolic_feeder.sv
// Accepts K beats of A columns / B rows and feeds them to a DIMxDIM array with per-lane skew.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int DIM = DEFAULT_DIM,
  parameter int DW  = DEFAULT_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KLEN_W-1:0]        k_len,
  input  logic [DIM-1:0][DW-1:0]   a_col,
  input  logic [DIM-1:0][DW-1:0]   b_row,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DIM-1:0][DW-1:0]   aleft,
  output logic [DIM-1:0]           enleft,
  output logic [DIM-1:0]           cmleft,
  output logic [DIM-1:0][DW-1:0]   bup,
  output logic [DIM-1:0]           enup,
  output logic [DIM-1:0]           cmup,
  output logic                     busy,
  output logic                     done
);

  feeder_state_t     state;
  logic [KLEN_W-1:0] k_len_q;
  logic [KLEN_W-1:0] beat_cnt;
  logic              beat_fire;
  logic              beat_last;

  assign beat_fire = in_valid & in_ready;
  assign beat_last = beat_fire & (beat_cnt == k_len_q - KLEN_W'(1));

  // beat_cnt counts accepted beats in FEED and is reused as the drain timer in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k_len_q  <= '0;
      beat_cnt <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (k_len != '0) begin
              state    <= FEED;
              k_len_q  <= k_len;
              beat_cnt <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FEED: begin
          if (beat_fire) begin
            if (beat_last) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          // The deepest lane shows the last beat in the final drain cycle.
          if (beat_cnt == KLEN_W'(DIM - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    skew_line #(.DEPTH(i + 1), .DW(DW)) u_left (
      .clk      (clk),
      .rst      (rst),
      .en       (beat_fire),
      .cm       (beat_last),
      .data     (a_col[i]),
      .tap_en   (enleft[i]),
      .tap_cm   (cmleft[i]),
      .tap_data (aleft[i])
    );

    skew_line #(.DEPTH(i + 1), .DW(DW)) u_up (
      .clk      (clk),
      .rst      (rst),
      .en       (beat_fire),
      .cm       (beat_last),
      .data     (b_row[i]),
      .tap_en   (enup[i]),
      .tap_cm   (cmup[i]),
      .tap_data (bup[i])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: per-cycle model of the skewed feed built from the stimulus it drove.
`timescale 1ns/1ps
module tb_systolic_feeder;

  localparam int DIM  = 8;
  localparam int DW   = 32;
  localparam int LOGN = 512;

  typedef logic [DIM-1:0][DW-1:0] vec_t;
  typedef struct {int t; logic last; vec_t a; vec_t b;} beat_t;
  typedef struct {int ts; int tl; int k;} job_t;

  logic           clk;
  logic           rst;
  logic           start;
  logic [15:0]    k_len;
  vec_t           a_col, b_row;
  logic           in_valid, in_ready;
  vec_t           aleft, bup;
  logic [DIM-1:0] enleft, cmleft, enup, cmup;
  logic           busy, done;

  systolic_feeder #(.DIM(DIM), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .a_col(a_col), .b_row(b_row), .in_valid(in_valid), .in_ready(in_ready),
    .aleft(aleft), .enleft(enleft), .cmleft(cmleft),
    .bup(bup), .enup(enup), .cmup(cmup),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle output log, indexed by cycle number modulo LOGN.
  vec_t           log_al [LOGN];
  vec_t           log_bu [LOGN];
  logic [DIM-1:0] log_enl [LOGN], log_cml [LOGN], log_enu [LOGN], log_cmu [LOGN];
  logic [2:0]     log_ctl [LOGN];
  int             en_last_tot = 0;
  int             cm_tot = 0;

  always @(negedge clk) begin
    log_al[cyc % LOGN]  <= aleft;
    log_bu[cyc % LOGN]  <= bup;
    log_enl[cyc % LOGN] <= enleft;
    log_cml[cyc % LOGN] <= cmleft;
    log_enu[cyc % LOGN] <= enup;
    log_cmu[cyc % LOGN] <= cmup;
    log_ctl[cyc % LOGN] <= {busy, in_ready, done};
    en_last_tot         <= en_last_tot + int'(enleft[DIM-1]);
    cm_tot              <= cm_tot + $countones(cmleft);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DIM*DW-1:0] got, input logic [DIM*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  beat_t beats[$];
  job_t  jobs[$];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc <= c) cycle();
  endtask

  task automatic junk_inputs();
    in_valid = 1'b1;
    for (int i = 0; i < DIM; i++) begin
      a_col[i] = 32'hA5A5_0000 | 32'(i);
      b_row[i] = 32'h5A5A_0000 | 32'(i);
    end
  endtask

  // Issues start in the current cycle, then offers beats; gap bit n suppresses valid on FEED cycle n.
  // Spurious start/k_len pulses during FEED must be ignored.
  task automatic run_job(input int k, input logic [31:0] gap, input bit vary);
    job_t  j;
    beat_t b;
    int    n;
    int    beat;
    start = 1'b1;
    k_len = 16'(k);
    j.ts  = cyc;
    j.tl  = cyc;
    j.k   = k;
    cycle();
    n    = 0;
    beat = 0;
    while (beat < k) begin
      start = n[0];
      k_len = 16'd2;
      if (n < 32 && gap[n]) begin
        junk_inputs();
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        for (int i = 0; i < DIM; i++) begin
          a_col[i] = vary ? 32'((beat << 8) + i + 1) : 32'(i + 1);
          b_row[i] = 32'h0100_0000 + 32'((beat << 8) + i);
        end
        b.t    = cyc;
        b.last = (beat == k - 1);
        b.a    = a_col;
        b.b    = b_row;
        beats.push_back(b);
        j.tl = cyc;
        beat++;
      end
      n++;
      cycle();
    end
    start = 1'b0;
    k_len = '0;
    junk_inputs();
    jobs.push_back(j);
  endtask

  // Rebuilds the expected outputs of every cycle in [lo, hi] from the recorded beats and jobs.
  task automatic check_window(input int lo, input int hi);
    for (int w = lo; w <= hi; w++) begin
      logic [DIM-1:0] e_en, e_cm;
      vec_t           e_a, e_b;
      logic [2:0]     e_ctl;
      int             idx;
      e_en  = '0;
      e_cm  = '0;
      e_a   = '0;
      e_b   = '0;
      e_ctl = '0;
      for (int q = beats.size() - 1; q >= 0; q--) begin
        int lane;
        if (beats[q].t + DIM < w) break;
        lane = w - beats[q].t - 1;
        if (lane >= 0 && lane < DIM) begin
          e_en[lane] = 1'b1;
          e_cm[lane] = beats[q].last;
          e_a[lane]  = beats[q].a[lane];
          e_b[lane]  = beats[q].b[lane];
        end
      end
      foreach (jobs[m]) begin
        if (jobs[m].k == 0) begin
          if (w == jobs[m].ts + 1) e_ctl[0] = 1'b1;
        end else begin
          if (w > jobs[m].ts && w <= jobs[m].tl + DIM) e_ctl[2] = 1'b1;
          if (w > jobs[m].ts && w <= jobs[m].tl)       e_ctl[1] = 1'b1;
          if (w == jobs[m].tl + DIM + 1)               e_ctl[0] = 1'b1;
        end
      end
      idx = w % LOGN;
      check($sformatf("flags@%0d", w), {log_enl[idx], log_cml[idx], log_enu[idx], log_cmu[idx]},
            {e_en, e_cm, e_en, e_cm});
      check($sformatf("aleft@%0d", w), log_al[idx], e_a);
      check($sformatf("bup@%0d", w), log_bu[idx], e_b);
      check($sformatf("ctl@%0d", w), log_ctl[idx], e_ctl);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, tl, ts, r, e0, c0, cnt_l, cnt_u;
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; a_col = '0; b_row = '0;
    cycle();
    cycle();
    check("rst_flags", {enleft, enup, cmleft, cmup}, '0);
    check("rst_ctl", {busy, in_ready, done}, '0);
    check("rst_data", aleft | bup, '0);
    rst = 1'b0;
    cycle();

    // k_len=3, valid held high, a_col[i]=i+1
    run_job(3, 32'h0, 1'b0);
    t0 = beats[0].t;
    tl = jobs[0].tl;
    wait_until(tl + DIM + 3);
    check_window(jobs[0].ts, tl + DIM + 3);
    check("a5_at_t0+6", log_al[(t0 + 6) % LOGN][5], 6);
    check("en5_at_t0+5", log_enl[(t0 + 5) % LOGN][5], 0);
    check("cm5_at_t0+7", log_cml[(t0 + 7) % LOGN][5], 0);
    check("cm5_at_t0+8", log_cml[(t0 + 8) % LOGN][5], 1);
    check("done_at_t0+11", log_ctl[(t0 + 2 + DIM + 1) % LOGN][0], 1);
    beats.delete(); jobs.delete();

    // k_len=4 with a bubble on the second FEED cycle
    run_job(4, 32'h2, 1'b1);
    ts = jobs[0].ts;
    tl = jobs[0].tl;
    wait_until(tl + DIM + 3);
    check_window(ts, tl + DIM + 3);
    for (int i = 0; i < DIM; i++) begin
      cnt_l = 0;
      cnt_u = 0;
      for (int w = ts; w <= tl + DIM + 3; w++) begin
        cnt_l += int'(log_enl[w % LOGN][i]);
        cnt_u += int'(log_enu[w % LOGN][i]);
      end
      check($sformatf("gap_beats_left%0d", i), cnt_l, 4);
      check($sformatf("gap_beats_up%0d", i), cnt_u, 4);
    end
    beats.delete(); jobs.delete();

    // null job
    run_job(0, 32'h0, 1'b0);
    ts = jobs[0].ts;
    wait_until(ts + 5);
    check_window(ts, ts + 5);
    beats.delete(); jobs.delete();

    // back-to-back: second start lands in the done cycle of the first
    run_job(2, 32'h0, 1'b1);
    tl = jobs[0].tl;
    while (cyc < tl + DIM + 1) cycle();
    run_job(3, 32'h0, 1'b1);
    wait_until(jobs[1].tl + DIM + 3);
    check_window(jobs[0].ts, jobs[1].tl + DIM + 3);
    t0 = beats[2].t;
    check("b2b_en0", log_enl[(t0 + 1) % LOGN][0], 1);
    check("b2b_a0", log_al[(t0 + 1) % LOGN][0], beats[2].a[0]);
    cnt_l = 0;
    for (int w = jobs[0].ts; w <= jobs[1].tl + DIM + 3; w++) cnt_l += int'(log_cml[w % LOGN][0]);
    check("b2b_cm0_count", cnt_l, 2);
    beats.delete(); jobs.delete();

    // reset during DRAIN of a k_len=5 job
    run_job(5, 32'h0, 1'b1);
    cycle();
    cycle();
    r   = cyc;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_flags", {enleft, enup, cmleft, cmup}, '0);
    check("midrst_ctl", {busy, in_ready, done}, '0);
    check("midrst_data", aleft | bup, '0);
    wait_until(r + DIM + 3);
    check_window(jobs[0].ts, r);
    for (int w = r + 1; w <= r + DIM + 3; w++) begin
      check($sformatf("postrst_flags@%0d", w),
            {log_enl[w % LOGN], log_cml[w % LOGN], log_enu[w % LOGN], log_cmu[w % LOGN]}, '0);
      check($sformatf("postrst_ctl@%0d", w), log_ctl[w % LOGN], '0);
    end
    beats.delete(); jobs.delete();
    run_job(3, 32'h0, 1'b0);
    t0 = beats[0].t;
    tl = jobs[0].tl;
    wait_until(tl + DIM + 3);
    check_window(jobs[0].ts, tl + DIM + 3);
    check("rerun_a5", log_al[(t0 + 6) % LOGN][5], 6);
    beats.delete(); jobs.delete();

    // maximum job length
    e0 = en_last_tot;
    c0 = cm_tot;
    run_job(65535, 32'h0, 1'b1);
    tl = jobs[0].tl;
    wait_until(tl + DIM + 3);
    check_window(tl - 3, tl + DIM + 3);
    check("big_beats_lane7", en_last_tot - e0, 65535);
    check("big_cm_total", cm_tot - c0, DIM);
    beats.delete(); jobs.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
